// File: rtl/total_alu.sv
// MIPS-style 32-bit ALU with a sequential shift-add MULTU unit feeding HI/LO.
// Optional macro ALU_BUSY_EN adds a busy output that is high while the multiplier runs.
module total_alu #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
`ifdef ALU_BUSY_EN
  output logic             busy,
`endif
  output logic [WIDTH-1:0] Output
);

  localparam logic [5:0] OP_AND   = 6'd36;
  localparam logic [5:0] OP_OR    = 6'd37;
  localparam logic [5:0] OP_ADD   = 6'd32;
  localparam logic [5:0] OP_SUB   = 6'd34;
  localparam logic [5:0] OP_SLT   = 6'd42;
  localparam logic [5:0] OP_SRL   = 6'd2;
  localparam logic [5:0] OP_MULTU = 6'd25;
  localparam logic [5:0] OP_MFHI  = 6'd16;
  localparam logic [5:0] OP_MFLO  = 6'd18;

  localparam logic IDLE = 1'b0;
  localparam logic BUSY = 1'b1;

  localparam int CW = $clog2(MUL_CYCLES);

  logic                 state_reg;
  logic [5:0]           sig_prev_reg;
  logic [CW-1:0]        count_reg;
  logic [2*WIDTH-1:0]   acc_reg;
  logic [2*WIDTH-1:0]   acc_next;
  logic [2*WIDTH-1:0]   mcand_reg;
  logic [WIDTH-1:0]     mplier_reg;
  logic [WIDTH-1:0]     hi_reg;
  logic [WIDTH-1:0]     lo_reg;
  logic                 start;
  logic                 last_iter;

  // Edge-detected start: a held 25 must leave and come back to retrigger.
  assign start     = (Signal == OP_MULTU) && (state_reg == IDLE) && (sig_prev_reg != OP_MULTU);
  assign last_iter = (count_reg == CW'(MUL_CYCLES - 1));
  assign acc_next  = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;

`ifdef ALU_BUSY_EN
  assign busy = (state_reg == BUSY);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      sig_prev_reg <= '0;
      count_reg    <= '0;
      acc_reg      <= '0;
      mcand_reg    <= '0;
      mplier_reg   <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
    end else begin
      sig_prev_reg <= Signal;
      if (state_reg == IDLE) begin
        if (start) begin
          mcand_reg  <= {{WIDTH{1'b0}}, dataA};
          mplier_reg <= dataB;
          acc_reg    <= '0;
          count_reg  <= '0;
          state_reg  <= BUSY;
        end
      end else begin
        acc_reg    <= acc_next;
        mcand_reg  <= mcand_reg << 1;
        mplier_reg <= mplier_reg >> 1;
        count_reg  <= count_reg + 1'b1;
        if (last_iter) begin
          {hi_reg, lo_reg} <= acc_next;
          state_reg        <= IDLE;
        end
      end
    end
  end

  always_comb begin
    Output = '0;
    case (Signal)
      OP_AND:  Output = dataA & dataB;
      OP_OR:   Output = dataA | dataB;
      OP_ADD:  Output = dataA + dataB;
      OP_SUB:  Output = dataA - dataB;
      OP_SLT:  Output = {{(WIDTH-1){1'b0}}, ($signed(dataA) < $signed(dataB))};
      OP_SRL:  Output = dataA >> dataB[4:0];
      OP_MFHI: Output = hi_reg;
      OP_MFLO: Output = lo_reg;
      default: Output = '0;
    endcase
  end

endmodule

// File: tb/tb_total_alu.sv
// Directed bench for total_alu: a reference model plus per-cycle comparison
// and hand-computed spot values.
module tb_total_alu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] dataA = '0;
  logic [31:0] dataB = '0;
  logic [5:0]  Signal = '0;
  logic [31:0] Output;
`ifdef ALU_BUSY_EN
  logic        busy;
`endif

  int compared = 0;
  int mismatched = 0;

  total_alu dut (
    .clk    (clk),
    .reset  (reset),
    .dataA  (dataA),
    .dataB  (dataB),
    .Signal (Signal),
`ifdef ALU_BUSY_EN
    .busy   (busy),
`endif
    .Output (Output)
  );

  always #5 clk = ~clk;

  // Reference model: a multiply finishes 32 edges after its start edge with a*b.
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [63:0] m_prod = '0;
  logic [5:0]  m_prev = '0;
  int          m_rem = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi = '0; m_lo = '0; m_prev = '0; m_rem = 0; m_prod = '0;
    end else begin
      if (m_rem > 0) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) {m_hi, m_lo} = m_prod;
      end else if (Signal == 6'd25 && m_prev != 6'd25) begin
        m_prod = {32'd0, dataA} * {32'd0, dataB};
        m_rem = 32;
      end
      m_prev = Signal;
    end
  end

  function automatic logic [31:0] model_out(input logic [5:0] s, input logic [31:0] a,
                                            input logic [31:0] b);
    case (s)
      6'd36: return a & b;
      6'd37: return a | b;
      6'd32: return a + b;
      6'd34: return a - b;
      6'd42: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'd2:  return a >> b[4:0];
      6'd16: return m_hi;
      6'd18: return m_lo;
      default: return 32'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    logic [31:0] exp_v;
    exp_v = model_out(Signal, dataA, dataB);
    compared++;
    if (Output !== exp_v) begin
      mismatched++;
      $display("FAIL model sig=%0d a=%h b=%h got=%h want=%h", Signal, dataA, dataB, Output, exp_v);
    end
`ifdef ALU_BUSY_EN
    compared++;
    if (busy !== (m_rem > 0)) begin
      mismatched++;
      $display("FAIL busy got=%b want=%b", busy, (m_rem > 0));
    end
`endif
  end

  // Inputs held across exactly one rising edge; returns just after the following falling edge.
  task automatic apply(input logic [5:0] s, input logic [31:0] a, input logic [31:0] b);
    Signal = s; dataA = a; dataB = b;
    @(negedge clk);
    #1;
  endtask

  task automatic check_lit(input string name, input logic [31:0] want);
    compared++;
    if (Output !== want) begin
      mismatched++;
      $display("FAIL %s got=%0d want=%0d", name, Output, want);
    end else begin
      $display("check %s = %0d", name, Output);
    end
  endtask

  int busy_cnt;

  initial begin
    @(negedge clk); #1;
    reset = 1'b1;

    apply(6'd16, 32'd0, 32'd0);         check_lit("mfhi_reset", 32'd0);
    apply(6'd18, 32'd0, 32'd0);         check_lit("mflo_reset", 32'd0);
    apply(6'd36, 32'd12, 32'd10);       check_lit("and", 32'd8);
    apply(6'd37, 32'd12, 32'd10);       check_lit("or", 32'd14);
    apply(6'd32, 32'hFFFFFFFF, 32'd1);  check_lit("add_wrap", 32'd0);
    apply(6'd34, 32'd3, 32'd5);         check_lit("sub_wrap", 32'd4294967294);
    apply(6'd42, 32'hFFFFFFFF, 32'd1);  check_lit("slt_neg", 32'd1);
    apply(6'd42, 32'd1, 32'hFFFFFFFF);  check_lit("slt_pos", 32'd0);
    apply(6'd2, 32'd256, 32'd4);        check_lit("srl", 32'd16);
    apply(6'd2, 32'd256, 32'd36);       check_lit("srl_b40", 32'd16);
    apply(6'd7, 32'd5, 32'd6);          check_lit("undef_op", 32'd0);

    // Max operands, held at 25 past completion: must not restart.
    for (int i = 0; i < 35; i++) apply(6'd25, 32'hFFFFFFFF, 32'hFFFFFFFF);
    apply(6'd16, 32'd0, 32'd0);         check_lit("mul_max_hi", 32'd4294967294);
    apply(6'd18, 32'd0, 32'd0);         check_lit("mul_max_lo", 32'd1);

    // One-cycle start, then ALU traffic while busy.
    apply(6'd25, 32'd123456, 32'd789);
    for (int i = 0; i < 40; i++) begin
      apply(6'd32, 32'(i * 1000003), 32'(32'hF0000000 + i));
      if (i == 5) begin
        apply(6'd18, 32'd0, 32'd0);     check_lit("mflo_old_busy", 32'd1);
      end
    end
    apply(6'd18, 32'd0, 32'd0);         check_lit("mul_lo", 32'd97406784);
    apply(6'd16, 32'd0, 32'd0);         check_lit("mul_hi", 32'd0);

    // Prior product 6, then abort 5*7 with reset.
    apply(6'd25, 32'd2, 32'd3);
    for (int i = 0; i < 32; i++) apply(6'd16, 32'd0, 32'd0);
    apply(6'd18, 32'd0, 32'd0);         check_lit("prior_lo", 32'd6);
    apply(6'd25, 32'd5, 32'd7);
    for (int i = 0; i < 8; i++) apply(6'd18, 32'd0, 32'd0);
    reset = 1'b0;
    #1;                                 check_lit("lo_async_reset", 32'd0);
    Signal = 6'd16; #1;                 check_lit("hi_async_reset", 32'd0);
    @(negedge clk); #1;
    reset = 1'b1;

    busy_cnt = 0;
    apply(6'd25, 32'd5, 32'd7);
`ifdef ALU_BUSY_EN
    if (busy === 1'b1) busy_cnt++;
`endif
    for (int i = 0; i < 32; i++) begin
      apply(6'd18, 32'd0, 32'd0);
      if (i < 31) check_lit("mflo_during_busy", 32'd0);
`ifdef ALU_BUSY_EN
      if (busy === 1'b1) busy_cnt++;
`endif
    end
    check_lit("restart_lo", 32'd35);
`ifdef ALU_BUSY_EN
    compared++;
    if (busy_cnt != 32) begin
      mismatched++;
      $display("FAIL busy_cycles got=%0d want=32", busy_cnt);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
